// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed RAM that terminates the dmem request/response interface
package dmem_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

module dmem_responder import dmem_pkg::*; #(
  parameter int          dmem_depth    = 10,
  parameter int          read_latency  = 1,
  parameter int          write_latency = 1,
  parameter int          fence_latency = 4,
  parameter logic [31:0] base_addr     = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output logic        err
);
  localparam int rw_lat  = read_latency > write_latency ? read_latency : write_latency;
  localparam int max_lat = rw_lat > fence_latency ? rw_lat : fence_latency;
  localparam int cw      = $clog2(max_lat) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, FENCE} state_t;
  state_t                state;
  logic [cw-1:0]         cnt;
  logic                  ready;
  logic [31:0]           rdata;
  logic [31:0]           data;
  logic [31:0]           ram [2**dmem_depth];
  logic                  fence;
  logic                  store;
  logic                  in_win;
  logic                  accept;
  logic                  violation;
  logic [dmem_depth-1:0] idx;
  logic [cw-1:0]         lat_m1;
  logic [31:0]           word;
  logic                  unused;
  assign unused    = ^{dmem_in.mem_instr, dmem_in.mem_addr[1:0]};
  assign fence     = dmem_in.mem_fence;
  assign store     = !fence && |dmem_in.mem_wstrb;
  assign idx       = dmem_in.mem_addr[dmem_depth+1:2];
  assign in_win    = dmem_in.mem_addr[31:dmem_depth+2] == base_addr[31:dmem_depth+2];
  // the ready cycle doubles as an acceptance slot so requests can run back to back
  assign accept    = dmem_in.mem_valid && !reset && (state == IDLE || ready);
  assign violation = dmem_in.mem_valid && state != IDLE && !ready;
  assign lat_m1    = fence ? cw'(fence_latency - 1) : store ? cw'(write_latency - 1) : cw'(read_latency - 1);
  assign word      = (!fence && !store && in_win) ? ram[idx] : '0;
  assign dmem_out  = '{mem_rdata: rdata, mem_ready: ready};
  // byte-strobed RAM write at the edge that accepts an in-window store
  always_ff @(posedge clock) begin
    if (accept && store && in_win)
      for (int b = 0; b < 4; b++)
        if (dmem_in.mem_wstrb[b]) ram[idx][8*b +: 8] <= dmem_in.mem_wdata[8*b +: 8];
  end
  // request FSM: ready/rdata registered so they go high exactly latency cycles after acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      err <= err | violation | (accept && !fence && !in_win);
      if (accept) begin
        state <= fence ? FENCE : WAIT;
        cnt   <= lat_m1;
        data  <= word;
        ready <= lat_m1 == '0;
        rdata <= lat_m1 == '0 ? word : '0;
      end else if (state != IDLE && cnt != '0) begin
        cnt   <= cnt - 1'b1;
        ready <= cnt == cw'(1);
        rdata <= cnt == cw'(1) ? data : '0;
      end else begin
        state <= IDLE;
        ready <= 1'b0;
        rdata <= '0;
      end
    end
  end
endmodule
